fifo_level_ctr: RTL

Parametrised, fully synchronous successor to the SCSI/DMA FIFO full/empty counter. It tracks FIFO occupancy for any depth and generates modulo-DEPTH write and read pointers. It also produces full, empty, almost-full and almost-empty flags, plus sticky overflow and underflow errors. It sits between the DMA/SCSI byte-lane steering logic and the FIFO RAM, and drives the RAM addresses and the flow-control flags.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_ptr_wrap.sv | 33 +++
 rtl/fifo_level_ctr.sv | 99 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO occupancy counter and its pointer registers.
package fifo_pkg;

  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AFULL_TH  = 6;
  localparam int DEF_AEMPTY_TH = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // COUNT must represent DEPTH itself, hence one bit more than a pointer.
  function automatic int cnt_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEF_AW = clog2(DEF_DEPTH);
  localparam int DEF_CW = cnt_width(DEF_DEPTH);

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH pointer register with enable and synchronous clear; 1-cycle update.
// Clear wins over enable; the pointer wraps DEPTH-1 -> 0 for any DEPTH.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] r_ptr;
  logic [AW-1:0] w_ptr_inc;

  assign w_ptr_inc = (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= w_ptr_inc;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_level_ctr.sv
// FIFO occupancy counter: RAM pointers, registered level flags and sticky overflow/underflow.
// 1-cycle latency; requests against a full/empty FIFO are dropped and flagged, never stalled.
module fifo_level_ctr
  import fifo_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH,
  localparam int AW       = clog2(DEPTH),
  localparam int CW       = cnt_width(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_FIFO_,
  input  logic          FLUSH,
  input  logic          INCFIFO,
  input  logic          DECFIFO,
  input  logic          ERR_CLR,
  output logic [AW-1:0] WR_PTR,
  output logic [AW-1:0] RD_PTR,
  output logic [CW-1:0] COUNT,
  output logic          FIFOEMPTY,
  output logic          FIFOFULL,
  output logic          FIFOAFULL,
  output logic          FIFOAEMPTY,
  output logic          OVERFLOW,
  output logic          UNDERFLOW
);

  if (DEPTH < 2 || AEMPTY_TH < 0 || AEMPTY_TH >= AFULL_TH || AFULL_TH >= DEPTH) begin : g_bad_params
    $fatal(1, "fifo_level_ctr: illegal DEPTH/AFULL_TH/AEMPTY_TH combination");
  end

  logic [CW-1:0] r_cnt;
  logic          r_empty;
  logic          r_full;
  logic          r_afull;
  logic          r_aempty;
  logic          r_ovf;
  logic          r_unf;

  logic          w_inc_ok;
  logic          w_dec_ok;
  logic          w_inc_rej;
  logic          w_dec_rej;
  logic [CW-1:0] w_cnt_nxt;

  // A flushed cycle ignores requests entirely, so nothing counts as rejected.
  assign w_inc_ok  = INCFIFO & ~r_full  & ~FLUSH;
  assign w_dec_ok  = DECFIFO & ~r_empty & ~FLUSH;
  assign w_inc_rej = INCFIFO &  r_full  & ~FLUSH;
  assign w_dec_rej = DECFIFO &  r_empty & ~FLUSH;

  assign w_cnt_nxt = FLUSH ? '0 : r_cnt + CW'(w_inc_ok) - CW'(w_dec_ok);

  always_ff @(posedge CLK or negedge RST_FIFO_) begin
    if (!RST_FIFO_) begin
      r_cnt    <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_empty  <= (w_cnt_nxt == '0);
      r_full   <= (w_cnt_nxt == CW'(DEPTH));
      r_afull  <= (w_cnt_nxt >= CW'(AFULL_TH));
      r_aempty <= (w_cnt_nxt <= CW'(AEMPTY_TH));
      r_ovf    <= w_inc_rej | (r_ovf & ~ERR_CLR);
      r_unf    <= w_dec_rej | (r_unf & ~ERR_CLR);
    end
  end

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_wr_ptr (
    .i_clk   (CLK),
    .i_rst_n (RST_FIFO_),
    .i_clr   (FLUSH),
    .i_en    (w_inc_ok),
    .o_ptr   (WR_PTR)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH)) u_rd_ptr (
    .i_clk   (CLK),
    .i_rst_n (RST_FIFO_),
    .i_clr   (FLUSH),
    .i_en    (w_dec_ok),
    .o_ptr   (RD_PTR)
  );

  assign COUNT      = r_cnt;
  assign FIFOEMPTY  = r_empty;
  assign FIFOFULL   = r_full;
  assign FIFOAFULL  = r_afull;
  assign FIFOAEMPTY = r_aempty;
  assign OVERFLOW   = r_ovf;
  assign UNDERFLOW  = r_unf;

endmodule
